// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg
// Shared definitions for the SDRAM pattern writer and the read-back stage:
// FSM state encodings, pattern codes, LFSR seed/tap mask, checkerboard words
// and the LFSR step function. Both sides import this package so the pattern
// written and the pattern expected can never drift apart.
package sdram_test_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_DELAY = 4'd1,
    ST_WRITE = 4'd2,
    ST_DONE  = 4'd15
  } testStateT;

  typedef enum logic [1:0] {
    PAT_ADDR     = 2'd0,
    PAT_NOT_ADDR = 2'd1,
    PAT_LFSR     = 2'd2,
    PAT_CHECKER  = 2'd3
  } patternT;

  localparam logic [DATA_W-1:0] LFSR_SEED     = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [DATA_W-1:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [DATA_W-1:0] CHECKER_EVEN  = 16'hAAAA;
  localparam logic [DATA_W-1:0] CHECKER_ODD   = 16'h5555;

  // One LFSR step: feedback is the XOR of the tapped bits, shifted in at the top.
  function automatic logic [DATA_W-1:0] lfsrStep(input logic [DATA_W-1:0] cur);
    return {^(cur & LFSR_TAP_MASK), cur[DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/sdram_test_pattern_gen.sv
// sdram_test_pattern_gen
// Purely combinational pattern word generator shared by writer and checker.
// Ports:
//   iPATTERN_SEL : pattern code (address, inverted address, LFSR, checkerboard)
//   iADDR        : low 16 bits of the word address being generated
//   iLFSR        : LFSR state belonging to the previous word (or the seed)
//   iSTEP        : advance the LFSR once before producing the word
//   oDATA        : pattern word for this address
//   oLFSR_NEXT   : LFSR state to keep for this word
module sdram_test_pattern_gen
  import sdram_test_pkg::*;
(
  input  patternT           iPATTERN_SEL,
  input  logic [DATA_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iLFSR,
  input  logic              iSTEP,
  output logic [DATA_W-1:0] oDATA,
  output logic [DATA_W-1:0] oLFSR_NEXT
);

  logic [DATA_W-1:0] lfsrNext;

  always_comb begin
    lfsrNext = iSTEP ? lfsrStep(iLFSR) : iLFSR;
    oDATA    = '0;
    unique case (iPATTERN_SEL)
      PAT_ADDR:     oDATA = iADDR;
      PAT_NOT_ADDR: oDATA = ~iADDR;
      PAT_LFSR:     oDATA = lfsrNext;
      PAT_CHECKER:  oDATA = iADDR[0] ? CHECKER_ODD : CHECKER_EVEN;
      default:      oDATA = '0;
    endcase
  end

  assign oLFSR_NEXT = lfsrNext;

endmodule

// File: rtl/sdram_pattern_writer.sv
// sdram_pattern_writer
// Fills NUM_WORDS consecutive SDRAM words starting at BASE_ADDR with a
// reproducible 16-bit pattern, then holds a level done flag until a rerun.
// Ports:
//   iCLK, iRST        : clock, asynchronous active-high reset
//   iSTART            : rerun request (rising edge, only acted on when done)
//   iPATTERN_SEL      : pattern code, captured when the write phase begins
//   iWAIT_REQUEST     : slave stall
//   oWR_EN/ADDR/DATA  : Avalon-style write request
//   oBUSY             : delay or write phase in progress
//   oTEST_WRITE_DONE  : region fully written
//   oDBG_STATE        : current FSM state
//
// Write handshake: a word transfers on every rising edge where oWR_EN is high
// and iWAIT_REQUEST is low. While iWAIT_REQUEST is high, oWR_EN, oWR_ADDR and
// oWR_DATA are held unchanged; oWR_EN never drops before its word transfers.
module sdram_pattern_writer
  import sdram_test_pkg::*;
#(
  parameter int              NUM_WORDS   = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 25'd0,
  parameter int              START_DELAY = 1000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [1:0]        iPATTERN_SEL,
  input  logic              iWAIT_REQUEST,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [DATA_W-1:0] oWR_DATA,
  output logic              oBUSY,
  output logic              oTEST_WRITE_DONE,
  output testStateT         oDBG_STATE
);

  testStateT         stateQ, stateD;
  logic              startQ;
  logic              startRise;
  logic [31:0]       delayCnt;
  logic              delayDone;
  logic [23:0]       idxQ;
  logic              lastWord;
  logic              accept;
  logic              enterWrite;
  logic              wrEnQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic [DATA_W-1:0] lfsrQ;
  patternT           selQ;
  logic              busyQ;
  logic              doneQ;

  patternT           genSel;
  logic [ADDR_W-1:0] genAddr;
  logic [DATA_W-1:0] genLfsr;
  logic              genStep;
  logic [DATA_W-1:0] genData;
  logic [DATA_W-1:0] genLfsrNext;

  // The edge detector runs in every state, so a level that is already high
  // when the FSM reaches ST_DONE is not mistaken for a new request.
  assign startRise  = iSTART && !startQ;
  assign delayDone  = (START_DELAY == 0) || (delayCnt == 32'(START_DELAY - 1));
  assign enterWrite = (stateQ == ST_DELAY) && delayDone;
  assign accept     = (stateQ == ST_WRITE) && wrEnQ && !iWAIT_REQUEST;
  assign lastWord   = (idxQ == 24'(NUM_WORDS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) stateQ <= ST_IDLE;
    else      stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_IDLE:  stateD = ST_DELAY;
      ST_DELAY: if (delayDone) stateD = ST_WRITE;
      ST_WRITE: if (accept && lastWord) stateD = ST_DONE;
      ST_DONE:  if (startRise) stateD = ST_DELAY;
      default:  stateD = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they change in the same
  // cycle as the state register, without any input-to-output path.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      startQ   <= 1'b0;
      delayCnt <= '0;
    end else begin
      busyQ    <= (stateD == ST_DELAY) || (stateD == ST_WRITE);
      doneQ    <= (stateD == ST_DONE);
      startQ   <= iSTART;
      delayCnt <= (stateQ == ST_DELAY) ? delayCnt + 32'd1 : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-word generation: on entry the generator sees word 0 (base address,
  // seed, no step, live pattern select); afterwards it sees the following
  // address and steps the LFSR held for the current word.
  // ---------------------------------------------------------------------------
  always_comb begin
    genSel  = enterWrite ? patternT'(iPATTERN_SEL) : selQ;
    genAddr = enterWrite ? BASE_ADDR : addrQ + 25'd1;
    genLfsr = enterWrite ? LFSR_SEED : lfsrQ;
    genStep = !enterWrite;
  end

  sdram_test_pattern_gen u_gen (
    .iPATTERN_SEL (genSel),
    .iADDR        (genAddr[DATA_W-1:0]),
    .iLFSR        (genLfsr),
    .iSTEP        (genStep),
    .oDATA        (genData),
    .oLFSR_NEXT   (genLfsrNext)
  );

  // ---------------------------------------------------------------------------
  // Write datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrEnQ <= 1'b0;
      addrQ <= BASE_ADDR;
      dataQ <= '0;
      idxQ  <= '0;
      lfsrQ <= LFSR_SEED;
      selQ  <= PAT_ADDR;
    end else if (enterWrite) begin
      wrEnQ <= 1'b1;
      addrQ <= genAddr;
      dataQ <= genData;
      idxQ  <= '0;
      lfsrQ <= genLfsrNext;
      selQ  <= patternT'(iPATTERN_SEL);
    end else if (accept) begin
      idxQ <= idxQ + 24'd1;
      if (lastWord) begin
        wrEnQ <= 1'b0;
      end else begin
        addrQ <= genAddr;
        dataQ <= genData;
        lfsrQ <= genLfsrNext;
      end
    end else if (stateQ != ST_WRITE) begin
      wrEnQ <= 1'b0;
    end
  end

  assign oWR_EN           = wrEnQ;
  assign oWR_ADDR         = addrQ;
  assign oWR_DATA         = dataQ;
  assign oBUSY            = busyQ;
  assign oTEST_WRITE_DONE = doneQ;
  assign oDBG_STATE       = stateQ;

endmodule

// File: tb/tb_sdram_pattern_writer.sv
module tb_sdram_pattern_writer;
  import sdram_test_pkg::*;

  localparam int          NUM_WORDS   = 16;
  localparam int          START_DELAY = 3;
  localparam logic [24:0] BASE_ADDR   = 25'h1FFFFF8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [1:0]  iPATTERN_SEL;
  logic        iWAIT_REQUEST;
  logic        oWR_EN;
  logic [24:0] oWR_ADDR;
  logic [15:0] oWR_DATA;
  logic        oBUSY;
  logic        oTEST_WRITE_DONE;
  testStateT   dbgState;

  always #5 iCLK = ~iCLK;

  sdram_pattern_writer #(
    .NUM_WORDS   (NUM_WORDS),
    .BASE_ADDR   (BASE_ADDR),
    .START_DELAY (START_DELAY)
  ) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iSTART           (iSTART),
    .iPATTERN_SEL     (iPATTERN_SEL),
    .iWAIT_REQUEST    (iWAIT_REQUEST),
    .oWR_EN           (oWR_EN),
    .oWR_ADDR         (oWR_ADDR),
    .oWR_DATA         (oWR_DATA),
    .oBUSY            (oBUSY),
    .oTEST_WRITE_DONE (oTEST_WRITE_DONE),
    .oDBG_STATE       (dbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [40:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          stallMode   = 0;
  int          stallLeft   = 0;
  bit          stallUsed   = 0;
  logic [24:0] stallAddr;
  int          stallSeen   = 0;
  int          wrEnCycles  = 0;
  int          stallCycles = 0;
  int          accCount    = 0;
  bit          lastAccepted = 0;
  longint      cyc      = 0;
  longint      firstCyc = -1;
  longint      lastCyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: the whole run's expected word stream from plain arithmetic.
  task automatic pushRun(input int sel);
    logic [15:0] l;
    logic [24:0] a;
    logic [15:0] d;
    logic        fb;
    l = 16'hACE1;
    exp_q.delete();
    wrEnCycles   = 0;
    stallCycles  = 0;
    accCount     = 0;
    stallSeen    = 0;
    lastAccepted = 0;
    firstCyc     = -1;
    for (int k = 0; k < NUM_WORDS; k++) begin
      a = BASE_ADDR + 25'(k);
      case (sel)
        0:       d = a[15:0];
        1:       d = ~a[15:0];
        2:       d = l;
        default: d = a[0] ? 16'h5555 : 16'hAAAA;
      endcase
      exp_q.push_back({a, d});
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      l  = {fb, l[15:1]};
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stall driver: none, random, or a single 5-cycle stall on stallAddr
  // ---------------------------------------------------------------------------
  always @(posedge iCLK) begin
    #1;
    case (stallMode)
      1: iWAIT_REQUEST = ($urandom_range(0, 2) == 0);
      2: begin
        if (stallLeft > 0) begin
          iWAIT_REQUEST = 1'b1;
          stallLeft--;
        end else if (!stallUsed && oWR_EN && oWR_ADDR == stallAddr) begin
          iWAIT_REQUEST = 1'b1;
          stallLeft     = 4;
          stallUsed     = 1;
        end else begin
          iWAIT_REQUEST = 1'b0;
        end
      end
      default: iWAIT_REQUEST = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every presented word against the head of exp_q
  // ---------------------------------------------------------------------------
  always @(negedge iCLK) begin
    cyc++;
    if (!iRST) begin
      if (lastAccepted) begin
        check("done_after_last", {62'd0, oTEST_WRITE_DONE, oWR_EN}, 64'd2);
        lastAccepted = 0;
      end
      if (oWR_EN) begin
        wrEnCycles++;
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        if (iWAIT_REQUEST) stallCycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {39'd0, oWR_ADDR}, 64'hFFFF_FFFF);
        end else begin
          check("word", {22'd0, oWR_ADDR, oWR_DATA, oTEST_WRITE_DONE}, {22'd0, exp_q[0], 1'b0});
          if (oWR_ADDR == stallAddr) stallSeen++;
          if (!iWAIT_REQUEST) begin
            exp_q.pop_front();
            accCount++;
            if (exp_q.size() == 0) lastAccepted = 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!oTEST_WRITE_DONE && n < 2000) begin
      @(posedge iCLK); #1;
      n++;
    end
    check({name, "_done"}, {63'd0, oTEST_WRITE_DONE}, 64'd1);
    @(negedge iCLK); #1;
    check({name, "_all_words"}, 64'(exp_q.size()), 64'd0);
    check({name, "_wr_cycles"}, 64'(wrEnCycles), 64'(NUM_WORDS + stallCycles));
    check({name, "_contiguous"}, 64'(lastCyc - firstCyc + 1), 64'(wrEnCycles));
    check({name, "_state"}, {60'd0, dbgState}, 64'd15);
  endtask

  task automatic startRun(input int sel, input int mode);
    stallMode    = mode;
    stallUsed    = 0;
    stallLeft    = 0;
    iPATTERN_SEL = 2'(sel);
    pushRun(sel);
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    check("rerun_flags", {62'd0, oTEST_WRITE_DONE, oBUSY}, 64'd1);
    iSTART = 1'b0;
  endtask

  task automatic waitAccepted(input int target);
    int n;
    n = 0;
    while (accCount < target && n < 500) begin
      @(posedge iCLK); #1;
      n++;
    end
    check("reach_word", 64'(accCount >= target), 64'd1);
  endtask

  task automatic checkResetValues(input string name);
    check({name, "_wr_en"}, {63'd0, oWR_EN}, 64'd0);
    check({name, "_addr"}, {39'd0, oWR_ADDR}, {39'd0, BASE_ADDR});
    check({name, "_data"}, {48'd0, oWR_DATA}, 64'd0);
    check({name, "_flags"}, {62'd0, oBUSY, oTEST_WRITE_DONE}, 64'd0);
    check({name, "_state"}, {60'd0, dbgState}, 64'd0);
  endtask

  task automatic measureStart(input string name);
    int n;
    int busyCnt;
    n = 0;
    busyCnt = 0;
    while (!oWR_EN && n < 100) begin
      @(posedge iCLK); #1;
      n++;
      if (oBUSY && !oWR_EN) busyCnt++;
    end
    check({name, "_first_write"}, 64'(n), 64'(START_DELAY + 1));
    check({name, "_delay_busy"}, 64'(busyCnt), 64'(START_DELAY));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    iRST          = 1'b1;
    iSTART        = 1'b0;
    iWAIT_REQUEST = 1'b0;
    iPATTERN_SEL  = 2'd0;
    stallAddr     = BASE_ADDR + 25'd2;

    repeat (3) @(posedge iCLK);
    #1;
    checkResetValues("reset");

    // Basic run: automatic start, address pattern, no stalls.
    pushRun(0);
    iRST = 1'b0;
    measureStart("basic");
    waitDone("basic");

    // One 5-cycle stall on word 2 with the inverted-address pattern.
    startRun(1, 2);
    waitDone("stall");
    check("stall_word_cycles", 64'(stallSeen), 64'd6);
    check("stall_cycles", 64'(stallCycles), 64'd5);

    // LFSR with random stalls; select change and a held-high start mid-run
    // must both be ignored.
    startRun(2, 1);
    waitAccepted(3);
    iPATTERN_SEL = 2'd0;
    iSTART       = 1'b1;
    waitDone("lfsr");
    repeat (4) @(posedge iCLK);
    #1;
    check("start_level_ignored", {62'd0, oTEST_WRITE_DONE, oBUSY}, 64'd2);
    iSTART = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("start_fall_ignored", {62'd0, oTEST_WRITE_DONE, oBUSY}, 64'd2);

    // Checkerboard across the address wrap, with a start pulse mid-run.
    startRun(3, 1);
    waitAccepted(2);
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    waitDone("checker");
    repeat (3) @(posedge iCLK);
    #1;
    check("start_pulse_ignored", {62'd0, oTEST_WRITE_DONE, oBUSY}, 64'd2);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      startRun(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      waitDone("random");
    end

    // Reset in the middle of a run, then the automatic restart.
    startRun(2, 1);
    waitAccepted(5);
    @(posedge iCLK);
    #3;
    iRST = 1'b1;
    #1;
    checkResetValues("midrun_reset");
    stallMode = 0;
    pushRun(2);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    measureStart("restart");
    waitDone("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
